// File: rtl/mano_pkg.sv
// Shared constants for the accumulator execution controller:
// opcode values, FSM state encoding and the fixed data width.
package mano_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_CMA = 3'd4;
    localparam logic [2:0] OP_CLA = 3'd5;
    localparam logic [2:0] OP_CLE = 3'd6;
    localparam logic [2:0] OP_CME = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_EXEC    = 3'd3,
        S_WR_REQ  = 3'd4
    } state_t;

endpackage

// File: rtl/mano_exec_ctrl.sv
// Sequencer for the 8-bit accumulator ALU: takes one instruction,
// fetches its operand into DR, fires one ALU select, retires to AC/E.
module mano_exec_ctrl
    import mano_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              mem_rd_req,
    input  logic              mem_rd_gnt,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_req,
    input  logic              mem_wr_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              alu_and,
    output logic              alu_add,
    output logic              alu_lda,
    output logic              alu_com,
    output logic [DATA_W-1:0] alu_ac,
    output logic [DATA_W-1:0] alu_dr,
    input  logic [DATA_W-1:0] alu_acdata,
    input  logic              alu_cout,
    output logic              e_flag,
    output logic              busy,
    output logic              done
);

    state_t              r_state;
    logic [2:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_ac;
    logic [DATA_W-1:0]   r_dr;
    logic                r_e;
    logic                r_done;
    logic                w_exec;

    assign w_exec      = (r_state == S_EXEC);
    assign instr_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign mem_rd_req  = (r_state == S_RD_REQ);
    assign mem_wr_req  = (r_state == S_WR_REQ);
    assign mem_addr    = r_addr;
    assign mem_wr_data = r_ac;
    assign alu_ac      = r_ac;
    assign alu_dr      = r_dr;
    assign e_flag      = r_e;
    assign done        = r_done;

    assign alu_and = w_exec && (r_op == OP_AND);
    assign alu_add = w_exec && (r_op == OP_ADD);
    assign alu_lda = w_exec && (r_op == OP_LDA);
    assign alu_com = w_exec && (r_op == OP_CMA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= OP_AND;
            r_addr  <= '0;
            r_ac    <= '0;
            r_dr    <= '0;
            r_e     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_op   <= instr_op;
                        r_addr <= instr_addr;
                        if (instr_op == OP_STA)
                            r_state <= S_WR_REQ;
                        else if (instr_op[2])
                            r_state <= S_EXEC;
                        else
                            r_state <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (mem_rd_gnt)
                        r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (mem_rd_valid) begin
                        r_dr    <= mem_rd_data;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // CLA relies on the ALU driving zero with no select
                    unique case (r_op)
                        OP_AND, OP_LDA, OP_CMA, OP_CLA: r_ac <= alu_acdata;
                        OP_ADD: begin
                            r_ac <= alu_acdata;
                            r_e  <= alu_cout;
                        end
                        OP_CLE:  r_e <= 1'b0;
                        OP_CME:  r_e <= ~r_e;
                        default: r_ac <= r_ac;
                    endcase
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_WR_REQ: begin
                    if (mem_wr_gnt) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mano_exec_ctrl.sv
// Directed bench for mano_exec_ctrl with a behavioural ALU model;
// inputs change and outputs are checked on the falling clock edge.
module tb_mano_exec_ctrl;
    import mano_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] instr_op = 3'd0;
    logic [7:0] instr_addr = 8'd0;
    logic       mem_rd_req;
    logic       mem_rd_gnt = 1'b0;
    logic       mem_rd_valid = 1'b0;
    logic [7:0] mem_rd_data = 8'd0;
    logic       mem_wr_req;
    logic       mem_wr_gnt = 1'b0;
    logic [7:0] mem_addr;
    logic [7:0] mem_wr_data;
    logic       alu_and, alu_add, alu_lda, alu_com;
    logic [7:0] alu_ac, alu_dr, alu_acdata;
    logic       alu_cout;
    logic       e_flag, busy, done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mano_exec_ctrl #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_addr(instr_addr),
        .mem_rd_req(mem_rd_req), .mem_rd_gnt(mem_rd_gnt),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .mem_wr_req(mem_wr_req), .mem_wr_gnt(mem_wr_gnt),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .alu_and(alu_and), .alu_add(alu_add),
        .alu_lda(alu_lda), .alu_com(alu_com),
        .alu_ac(alu_ac), .alu_dr(alu_dr),
        .alu_acdata(alu_acdata), .alu_cout(alu_cout),
        .e_flag(e_flag), .busy(busy), .done(done)
    );

    // Accumulator ALU as the parent would instantiate it
    always_comb begin
        alu_acdata = 8'h00;
        alu_cout   = 1'b0;
        if (alu_and)
            alu_acdata = alu_ac & alu_dr;
        else if (alu_add)
            {alu_cout, alu_acdata} = {1'b0, alu_ac} + {1'b0, alu_dr};
        else if (alu_lda)
            alu_acdata = alu_dr;
        else if (alu_com)
            alu_acdata = ~alu_ac;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] addr);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_addr  = addr;
        step();
        instr_valid = 1'b0;
    endtask

    // Read op with immediate grant and data one idle cycle after grant
    task automatic rd_op(input logic [2:0] op, input logic [7:0] addr,
                         input logic [7:0] data);
        issue(op, addr);
        mem_rd_gnt = 1'b1;
        step();
        mem_rd_gnt = 1'b0;
        step();
        mem_rd_valid = 1'b1;
        mem_rd_data  = data;
        step();
        mem_rd_valid = 1'b0;
        step();
    endtask

    task automatic reg_op(input logic [2:0] op);
        issue(op, 8'h00);
        step();
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_ready", instr_ready, 1);
        chk("rst_ac", alu_ac, 8'h00);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_rdreq", mem_rd_req, 0);
        rst_n = 1'b1;
        step();

        // reset while waiting for read data
        issue(OP_LDA, 8'h33);
        chk("rd_req_hi", mem_rd_req, 1);
        mem_rd_gnt = 1'b1;
        step();
        mem_rd_gnt = 1'b0;
        chk("rdwait_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_rdreq", mem_rd_req, 0);
        chk("async_addr", mem_addr, 8'h00);
        step();
        rst_n = 1'b1;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 8'h99;
        step();
        mem_rd_valid = 1'b0;
        step();
        chk("ign_ac", alu_ac, 8'h00);
        chk("ign_dr", alu_dr, 8'h00);
        chk("ign_done", done, 0);
        chk("ign_busy", busy, 0);

        // LDA 0x10 -> 0x3C with step-by-step observation
        issue(OP_LDA, 8'h10);
        chk("lda_rdreq", mem_rd_req, 1);
        chk("lda_addr", mem_addr, 8'h10);
        chk("lda_ready", instr_ready, 0);
        mem_rd_gnt = 1'b1;
        step();
        mem_rd_gnt = 1'b0;
        chk("lda_rdreq_off", mem_rd_req, 0);
        step();
        chk("lda_sel_wait", alu_lda, 0);
        mem_rd_valid = 1'b1;
        mem_rd_data  = 8'h3C;
        step();
        mem_rd_valid = 1'b0;
        chk("lda_sel", alu_lda, 1);
        chk("lda_othersel", {alu_and, alu_add, alu_com}, 3'b000);
        chk("lda_done_early", done, 0);
        step();
        chk("lda_sel_off", alu_lda, 0);
        chk("lda_done", done, 1);
        chk("lda_ac", alu_ac, 8'h3C);
        chk("lda_e", e_flag, 0);
        step();
        chk("lda_done_once", done, 0);

        reg_op(OP_CMA);
        chk("cma_ac", alu_ac, 8'hC3);
        chk("cma_done", done, 1);

        // ADD with and without carry
        rd_op(OP_LDA, 8'h01, 8'hF0);
        chk("ldf0_ac", alu_ac, 8'hF0);
        rd_op(OP_ADD, 8'h02, 8'h20);
        chk("add1_ac", alu_ac, 8'h10);
        chk("add1_e", e_flag, 1);
        rd_op(OP_ADD, 8'h03, 8'h01);
        chk("add2_ac", alu_ac, 8'h11);
        chk("add2_e", e_flag, 0);

        // AND keeps E; CLA, CLE, CME
        rd_op(OP_LDA, 8'h04, 8'hAA);
        reg_op(OP_CME);
        chk("cme0_e", e_flag, 1);
        rd_op(OP_AND, 8'h05, 8'h0F);
        chk("and_ac", alu_ac, 8'h0A);
        chk("and_e", e_flag, 1);
        reg_op(OP_CLA);
        chk("cla_ac", alu_ac, 8'h00);
        chk("cla_e", e_flag, 1);
        reg_op(OP_CLE);
        chk("cle_e", e_flag, 0);
        reg_op(OP_CME);
        chk("cme1_e", e_flag, 1);
        chk("cme1_ac", alu_ac, 8'h00);
        reg_op(OP_CME);
        chk("cme2_e", e_flag, 0);
        chk("cme2_ac", alu_ac, 8'h00);

        // STA with grant withheld three cycles
        rd_op(OP_LDA, 8'h06, 8'h5A);
        issue(OP_STA, 8'h7F);
        for (int i = 0; i < 3; i++) begin
            chk("sta_wrreq", mem_wr_req, 1);
            chk("sta_rdreq", mem_rd_req, 0);
            chk("sta_addr", mem_addr, 8'h7F);
            chk("sta_data", mem_wr_data, 8'h5A);
            chk("sta_done", done, 0);
            step();
        end
        mem_wr_gnt = 1'b1;
        step();
        mem_wr_gnt = 1'b0;
        chk("sta_wrreq_off", mem_wr_req, 0);
        chk("sta_done_hi", done, 1);
        chk("sta_ac", alu_ac, 8'h5A);
        chk("sta_e", e_flag, 0);

        // back-to-back with instr_valid held through busy
        instr_valid = 1'b1;
        instr_op    = OP_CME;
        step();
        chk("b2b_busy", busy, 1);
        chk("b2b_ready", instr_ready, 0);
        instr_op = OP_CMA;
        step();
        chk("b2b_done1", done, 1);
        chk("b2b_e", e_flag, 1);
        chk("b2b_ready1", instr_ready, 1);
        step();
        instr_valid = 1'b0;
        chk("b2b_com", alu_com, 1);
        chk("b2b_busy2", busy, 1);
        step();
        chk("b2b_done2", done, 1);
        chk("b2b_ac", alu_ac, 8'hA5);
        step();
        chk("b2b_idle", busy, 0);
        chk("b2b_nodbl", done, 0);
        chk("b2b_ac2", alu_ac, 8'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
